// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ_MAX = 8;
  localparam int BEAT_W   = 4;

  // Index width for n items; never returns less than 1 so a 1-bit id survives n=2.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Producer handshake plus fifo_mem write-port bundle seen by the arbiter.
interface fifo_wr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
);

  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_data_in;
  logic               fifo_full;
  logic               fifo_threshold;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_threshold,
    output req_ready, fifo_wr, fifo_data_in, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_threshold,
    input  req_ready, fifo_wr, fifo_data_in, grant_valid, grant_id
  );

endinterface

// File: rtl/fifo_wr_arb_rr_picker.sv
// Combinational round-robin search: first set request strictly after i_last,
// wrapping, so the previous winner is always considered last.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic            o_any,
  output logic [IW-1:0]   o_winner
);

  always_comb begin
    int unsigned w_idx;
    logic [IW-1:0] w_sel;
    w_idx    = 0;
    w_sel    = '0;
    o_any    = 1'b0;
    o_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(i_last) + k) % NREQ;
      w_sel = IW'(w_idx);
      if (!o_any && i_req[w_sel]) begin
        o_any    = 1'b1;
        o_winner = w_sel;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one fifo_mem write port among NREQ
// valid/ready producers, with bounded bursts and full/threshold back-pressure.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic          clk,
  input logic          rst_n,
  fifo_wr_arb_if.slave bus
);

  localparam int IDW = clog2(NREQ);
  localparam logic [BEAT_W-1:0] BURST_L = BEAT_W'(BURST);
  localparam logic [BEAT_W-1:0] ONE_L   = BEAT_W'(1);

  state_t              r_state;
  logic                r_grant_valid;
  logic [IDW-1:0]      r_grant_id;
  logic [IDW-1:0]      r_last_grant;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [BEAT_W-1:0]   r_burst_lim;

  logic                w_any;
  logic [IDW-1:0]      w_winner;
  logic                w_in_grant;
  logic                w_sel_valid;
  logic [DW-1:0]       w_sel_data;
  logic                w_fifo_wr;
  logic [NREQ-1:0]     w_req_ready;
  logic [BEAT_W-1:0]   w_beat_nxt;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IDW)
  ) u_picker (
    .i_req    (bus.req_valid),
    .i_last   (r_last_grant),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_in_grant  = (r_state == GRANT);
  assign w_sel_valid = bus.req_valid[r_grant_id];
  assign w_sel_data  = bus.req_data[int'(r_grant_id)*DW +: DW];
  assign w_beat_nxt  = r_beat_cnt + ONE_L;

  // rst_n gates the strobes so a beat in flight during reset is neither written nor acknowledged.
  assign w_fifo_wr = rst_n & w_in_grant & w_sel_valid & ~bus.fifo_full;

  always_comb begin
    w_req_ready = '0;
    if (rst_n && w_in_grant && !bus.fifo_full) w_req_ready[r_grant_id] = 1'b1;
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.fifo_wr      = w_fifo_wr;
  assign bus.fifo_data_in = w_in_grant ? w_sel_data : '0;
  assign bus.grant_valid  = r_grant_valid;
  assign bus.grant_id     = r_grant_id;

  // Arbitration / grant FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_grant  <= IDW'(NREQ - 1);
      r_beat_cnt    <= '0;
      r_burst_lim   <= BURST_L;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state       <= GRANT;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_winner;
            r_last_grant  <= w_winner;
            r_beat_cnt    <= '0;
            r_burst_lim   <= bus.fifo_threshold ? ONE_L : BURST_L;
          end
        end
        GRANT: begin
          // A withdrawn requester forfeits the rest of its burst.
          if (!w_sel_valid) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
          end else if (w_fifo_wr) begin
            r_beat_cnt <= w_beat_nxt;
            if (w_beat_nxt == r_burst_lim) begin
              r_state       <= IDLE;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_full_write: assert property (@(posedge clk) !(w_fifo_wr && bus.fifo_full));
  a_ready_onehot:  assert property (@(posedge clk) $onehot0(w_req_ready));
  a_gv_state:      assert property (@(posedge clk) disable iff (!rst_n)
                                    r_grant_valid == (r_state == GRANT));
`endif

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one 8-bit `fifo_mem` write port among NREQ producers. Each producer uses a valid/ready handshake. The block grants one producer at a time for a bounded burst and drives `wr`/`data_in` of the FIFO directly. It never writes into a full FIFO and shortens bursts when the FIFO reports its threshold, which keeps `fifo_overflow` permanently low.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 8: data width; matches `fifo_mem` data_in.
- BURST, 4: maximum beats per grant (1..15).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  bit i: requester i has a beat on its data slice.
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW].
- req_ready  out  NREQ  bit i: beat i is accepted this cycle. One-hot or zero.
- fifo_wr  out  1  write strobe to `fifo_mem` `wr`.
- fifo_data_in  out  DW  write data to `fifo_mem` `data_in`.
- fifo_full  in  1  from `fifo_mem`.
- fifo_threshold  in  1  from `fifo_mem`.
- grant_valid  out  1  a grant is active (state GRANT).
- grant_id  out  clog2(NREQ)  index of the granted requester. Holds its last value when idle.

## Operation
- FSM has two states:
  - IDLE: arbitration cycle. No transfers.
  - GRANT: streaming from requester grant_id.
- IDLE -> GRANT when any req_valid bit is set.
  - Winner is the first valid requester found searching from (last_grant+1) mod NREQ upward, with wrap.
  - Registers: grant_id <= winner; last_grant <= winner; beat_cnt <= 0; burst_lim <= fifo_threshold ? 1 : BURST.
- In GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits = 0.
  - fifo_wr = req_valid[g] & !fifo_full.
  - fifo_data_in = req_data[g] in GRANT, 0 otherwise.
  - A transfer occurs on a cycle where fifo_wr=1. It increments beat_cnt.
- GRANT -> IDLE on the first of these:
  - a transfer with beat_cnt+1 == burst_lim;
  - req_valid[g]=0 (requester withdrew; no transfer that cycle).
- fifo_full in GRANT stalls the grant: no transfer, beat_cnt held, grant kept. There is no timeout.
- fifo_full or fifo_threshold while in IDLE does not block arbitration. A full FIFO only stalls after the grant.
- Producers must hold req_valid and data stable until ready. A requester dropping valid mid-burst loses the rest of its burst.
- Fairness: a requester that just finished has the lowest priority in the next arbitration.
- Arithmetic: beat_cnt is 4 bits. The comparison uses beat_cnt+1 at 4-bit width; it cannot overflow because BURST ≤ 15.

## Timing
- Reset values (synchronous, asserted at a posedge):
  - state=IDLE, grant_valid=0, grant_id=0, last_grant=NREQ-1 (requester 0 wins the first arbitration), beat_cnt=0, burst_lim=BURST.
  - fifo_wr=0, req_ready=0.
- Latency: req_valid rising before posedge k (FSM idle) -> GRANT after posedge k -> first beat written at posedge k+1.
- Full burst: BURST beats on consecutive cycles, then one IDLE bubble, then the next grant.
- Peak throughput is BURST/(BURST+1).
- fifo_wr and req_ready are combinational from registered state, req_valid and fifo_full. There are no other combinational paths.
- Reset asserted mid-burst: the beat in flight that cycle is not written (fifo_wr forced 0 while rst_n=0), and the FSM returns to IDLE.
- fifo_full and fifo_threshold are sampled the same cycle they are used. `fifo_mem` updates full one cycle after the write that fills it. The grant therefore stalls on the first cycle full is seen, and no write coincides with full=1.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, GRANT};
  - NREQ_MAX=8;
  - BEAT_W=4;
  - function clog2.
- Sub-module `rr_picker`: combinational round-robin search.
  - Inputs: req[NREQ], last[clog2(NREQ)].
  - Outputs: any, winner.
  - It is instantiated once and is reusable for a future read-side scheduler.
- Top level holds the FSM, the counters and the data mux.

## Test plan
- Single requester: req 2 valid with data 0x11..0x16 (6 beats), BURST=4.
  - Beats 0x11..0x14 are written on consecutive cycles.
  - One IDLE cycle follows, then 0x15 and 0x16.
  - grant_id stays 2 throughout.
- Round-robin: all 4 requesters valid continuously after reset.
  - Grant order is 0,1,2,3,0.
  - Each grant writes exactly 4 beats.
  - fifo_wr pattern is 1111_0 repeating.
- Full stall: the FIFO reaches 16 entries mid-burst from req 1.
  - fifo_wr=0 and req_ready=0 while full.
  - A reader pops one entry; the next beat is written 1 cycle after full drops.
  - fifo_overflow never asserts.
- Threshold: fifo_threshold=1 at arbitration.
  - Burst is limited to 1 beat per grant.
  - Grants rotate every 2 cycles.
- Withdraw and reset: req 3 drops valid after 2 beats.
  - FSM goes to IDLE.
  - The next grant goes to req 0 if it is valid.
  - Separately, rst_n=0 mid-burst: all outputs return to reset values at the next posedge, and the next grant goes to req 0.
- End-to-end check: drain the FIFO after the round-robin test.
  - The read order equals the write order: per-requester data monotonic, interleaved in blocks of 4.
  - fifo_underflow stays 0.
